// File: rtl/pong_game_ctrl.sv
// Pong game-state sequencer: scores, balls left, winner, text-layer enables and
// ball freeze/serve control. Every output comes straight from a flop.
module pong_game_ctrl #(
  parameter int BALLS     = 3,
  parameter int WIN_SCORE = 7,
  parameter int DELAY_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       miss1,
  input  logic       miss2,
  output logic [2:0] score1,
  output logic [2:0] score2,
  output logic [2:0] ball,
  output logic [2:0] winner,
  output logic [5:0] text_en,
  output logic       still,
  output logic       serve
);

  localparam int TW = $clog2(DELAY_CYC + 1);

  localparam logic [TW-1:0] TIMER_LOAD = TW'(DELAY_CYC - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [2:0]    BALLS_INIT = 3'(BALLS);
  localparam logic [2:0]    WIN        = 3'(WIN_SCORE);

  // text_en bit order: {score1, score2, rule, win, logo, ball}
  localparam logic [5:0] TXT_NEWGAME = 6'b111011;
  localparam logic [5:0] TXT_PLAY    = 6'b110001;
  localparam logic [5:0] TXT_WIN     = 6'b110110;
  localparam logic [5:0] TXT_TIE     = 6'b110010;

  typedef enum logic [1:0] {
    S_NEWGAME = 2'd0,
    S_PLAY    = 2'd1,
    S_NEWBALL = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    score1_q, score1_d;
  logic [2:0]    score2_q, score2_d;
  logic [2:0]    ball_q, ball_d;
  logic [2:0]    winner_q, winner_d;
  logic [5:0]    text_en_q, text_en_d;
  logic          still_q, still_d;
  logic          serve_q, serve_d;
  logic [2:0]    score1_inc, score2_inc;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    ball_d     = ball_q;
    winner_d   = winner_q;
    serve_d    = 1'b0;
    score1_inc = (score1_q == 3'd7) ? 3'd7 : score1_q + 3'd1;
    score2_inc = (score2_q == 3'd7) ? 3'd7 : score2_q + 3'd1;

    case (state_q)
      S_NEWGAME: begin
        if (start) begin
          state_d = S_PLAY;
          ball_d  = ball_q - 3'd1;
          serve_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (miss1 || miss2) begin
          if (miss2) score1_d = score1_inc;
          if (miss1) score2_d = score2_inc;
          timer_d = TIMER_LOAD;
          // Win and exhaustion are judged on the post-increment scores.
          if (score1_d >= WIN || score2_d >= WIN || ball_q == 3'd0) begin
            state_d = S_OVER;
            if (score1_d > score2_d)      winner_d = 3'd1;
            else if (score2_d > score1_d) winner_d = 3'd2;
            else                          winner_d = 3'd0;
          end else begin
            state_d = S_NEWBALL;
          end
        end
      end
      S_NEWBALL: begin
        if (timer_q == '0) begin
          if (start) begin
            state_d = S_PLAY;
            ball_d  = ball_q - 3'd1;
            serve_d = 1'b1;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      S_OVER: begin
        if (timer_q == '0) begin
          state_d  = S_NEWGAME;
          score1_d = 3'd0;
          score2_d = 3'd0;
          ball_d   = BALLS_INIT;
          winner_d = 3'd0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: state_d = S_NEWGAME;
    endcase

    // Display controls follow the upcoming state so they stay registered.
    still_d = (state_d != S_PLAY);
    case (state_d)
      S_NEWGAME: text_en_d = TXT_NEWGAME;
      S_OVER:    text_en_d = (winner_d != 3'd0) ? TXT_WIN : TXT_TIE;
      default:   text_en_d = TXT_PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_NEWGAME;
      timer_q   <= '0;
      score1_q  <= 3'd0;
      score2_q  <= 3'd0;
      ball_q    <= BALLS_INIT;
      winner_q  <= 3'd0;
      text_en_q <= TXT_NEWGAME;
      still_q   <= 1'b1;
      serve_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      score1_q  <= score1_d;
      score2_q  <= score2_d;
      ball_q    <= ball_d;
      winner_q  <= winner_d;
      text_en_q <= text_en_d;
      still_q   <= still_d;
      serve_q   <= serve_d;
    end
  end

  assign score1  = score1_q;
  assign score2  = score2_q;
  assign ball    = ball_q;
  assign winner  = winner_q;
  assign text_en = text_en_q;
  assign still   = still_q;
  assign serve   = serve_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: two instances (WIN_SCORE 7 and 2) share stimulus;
// directed scenarios plus random play checked against a phase/age game model.
module tb_pong_game_ctrl;

  localparam int D  = 4;
  localparam int NB = 3;

  localparam int P_NG = 0, P_PLAY = 1, P_NB = 2, P_OV = 3;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, miss1 = 1'b0, miss2 = 1'b0;

  logic [2:0] a_s1, a_s2, a_ball, a_win;
  logic [5:0] a_txt;
  logic       a_still, a_serve;
  logic [2:0] b_s1, b_s2, b_ball, b_win;
  logic [5:0] b_txt;
  logic       b_still, b_serve;

  int checks = 0;
  int errors = 0;

  wire [19:0] a_obs = {a_s1, a_s2, a_ball, a_win, a_txt, a_still, a_serve};
  wire [19:0] b_obs = {b_s1, b_s2, b_ball, b_win, b_txt, b_still, b_serve};

  pong_game_ctrl #(.BALLS(NB), .WIN_SCORE(7), .DELAY_CYC(D)) dut_a (
    .clk(clk), .rst(rst), .start(start), .miss1(miss1), .miss2(miss2),
    .score1(a_s1), .score2(a_s2), .ball(a_ball), .winner(a_win),
    .text_en(a_txt), .still(a_still), .serve(a_serve));

  pong_game_ctrl #(.BALLS(NB), .WIN_SCORE(2), .DELAY_CYC(D)) dut_b (
    .clk(clk), .rst(rst), .start(start), .miss1(miss1), .miss2(miss2),
    .score1(b_s1), .score2(b_s2), .ball(b_ball), .winner(b_win),
    .text_en(b_txt), .still(b_still), .serve(b_serve));

  always #5 clk = ~clk;

  // Game model: phase plus cycles spent in it; outputs derived from game facts.
  typedef struct {
    int phase;
    int age;
    int s1;
    int s2;
    int balls;
    int winner;
    bit serve;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mreset();
    mdl_t m;
    m.phase = P_NG; m.age = 0; m.s1 = 0; m.s2 = 0;
    m.balls = NB; m.winner = 0; m.serve = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int w, bit r, bit st, bit m1, bit m2);
    mdl_t n = m;
    n.serve = 1'b0;
    if (r) return mreset();
    if (m.phase == P_NG) begin
      if (st) begin n.phase = P_PLAY; n.balls--; n.serve = 1'b1; end
    end else if (m.phase == P_PLAY) begin
      if (m1 || m2) begin
        n.s2 = m.s2 + int'(m1); if (n.s2 > 7) n.s2 = 7;
        n.s1 = m.s1 + int'(m2); if (n.s1 > 7) n.s1 = 7;
        n.age = 0;
        if (n.s1 >= w || n.s2 >= w || n.balls == 0) begin
          n.phase  = P_OV;
          n.winner = (n.s1 > n.s2) ? 1 : (n.s2 > n.s1) ? 2 : 0;
        end else begin
          n.phase = P_NB;
        end
      end
    end else if (m.phase == P_NB) begin
      if (m.age >= D - 1 && st) begin
        n.phase = P_PLAY; n.balls--; n.serve = 1'b1;
      end else begin
        n.age = m.age + 1;
      end
    end else begin
      if (m.age >= D - 1) n = mreset();
      else n.age = m.age + 1;
    end
    return n;
  endfunction

  function automatic logic [19:0] mpack(mdl_t m);
    logic [5:0] t;
    if (m.phase == P_NG)      t = 6'b111011;
    else if (m.phase == P_OV) t = (m.winner != 0) ? 6'b110110 : 6'b110010;
    else                      t = 6'b110001;
    return {3'(m.s1), 3'(m.s2), 3'(m.balls), 3'(m.winner), t,
            m.phase != P_PLAY, m.serve};
  endfunction

  task automatic tick();
    @(posedge clk);
    ma = mstep(ma, 7, rst, start, miss1, miss2);
    mb = mstep(mb, 2, rst, start, miss1, miss2);
    #1;
  endtask

  task automatic serve_after(input int n);
    start = 1'b1;
    repeat (n) tick();
    start = 1'b0;
  endtask

  task automatic miss(input bit m1, input bit m2);
    miss1 = m1; miss2 = m2;
    tick();
    miss1 = 1'b0; miss2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick();
    checks++;
    if (a_obs !== {3'd0, 3'd0, 3'd3, 3'd0, 6'b111011, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_init got %h want %h", a_obs, {3'd0, 3'd0, 3'd3, 3'd0, 6'b111011, 1'b1, 1'b0});
    end
    rst = 1'b0;
    serve_after(1); miss(0, 1); serve_after(D); miss(0, 1); serve_after(D);
    checks++;
    if (a_obs !== {3'd2, 3'd0, 3'd0, 3'd0, 6'b110001, 1'b0, 1'b1}) begin
      errors++; $display("FAIL play_s1_2 got %h want %h", a_obs, {3'd2, 3'd0, 3'd0, 3'd0, 6'b110001, 1'b0, 1'b1});
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (a_obs !== {3'd0, 3'd0, 3'd3, 3'd0, 6'b111011, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_in_play got %h want %h", a_obs, {3'd0, 3'd0, 3'd3, 3'd0, 6'b111011, 1'b1, 1'b0});
    end
    checks++;
    if (b_obs !== {3'd0, 3'd0, 3'd3, 3'd0, 6'b111011, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_b got %h want %h", b_obs, {3'd0, 3'd0, 3'd3, 3'd0, 6'b111011, 1'b1, 1'b0});
    end
  endtask

  task automatic test_serve();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (a_obs !== {3'd0, 3'd0, 3'd2, 3'd0, 6'b110001, 1'b0, 1'b1}) begin
      errors++; $display("FAIL serve_start got %h want %h", a_obs, {3'd0, 3'd0, 3'd2, 3'd0, 6'b110001, 1'b0, 1'b1});
    end
    tick();
    checks++;
    if (a_obs !== {3'd0, 3'd0, 3'd2, 3'd0, 6'b110001, 1'b0, 1'b0}) begin
      errors++; $display("FAIL serve_one_cycle got %h want %h", a_obs, {3'd0, 3'd0, 3'd2, 3'd0, 6'b110001, 1'b0, 1'b0});
    end
  endtask

  task automatic test_holdoff();
    start = 1'b1; miss1 = 1'b1; tick(); miss1 = 1'b0;
    checks++;
    if (a_obs !== {3'd0, 3'd1, 3'd2, 3'd0, 6'b110001, 1'b1, 1'b0}) begin
      errors++; $display("FAIL holdoff_enter got %h want %h", a_obs, {3'd0, 3'd1, 3'd2, 3'd0, 6'b110001, 1'b1, 1'b0});
    end
    for (int i = 0; i < D - 1; i++) begin
      tick();
      checks++;
      if (a_serve !== 1'b0) begin
        errors++; $display("FAIL holdoff_early_serve cyc %0d got %b want 0", i, a_serve);
      end
    end
    tick(); start = 1'b0;
    checks++;
    if (a_obs !== {3'd0, 3'd1, 3'd1, 3'd0, 6'b110001, 1'b0, 1'b1}) begin
      errors++; $display("FAIL holdoff_serve got %h want %h", a_obs, {3'd0, 3'd1, 3'd1, 3'd0, 6'b110001, 1'b0, 1'b1});
    end
    miss(1, 0);
    checks++;
    if (a_obs !== {3'd0, 3'd2, 3'd1, 3'd0, 6'b110001, 1'b1, 1'b0}) begin
      errors++; $display("FAIL holdoff_second got %h want %h", a_obs, {3'd0, 3'd2, 3'd1, 3'd0, 6'b110001, 1'b1, 1'b0});
    end
    checks++;
    if (b_obs !== {3'd0, 3'd2, 3'd1, 3'd2, 6'b110110, 1'b1, 1'b0}) begin
      errors++; $display("FAIL win_score_over got %h want %h", b_obs, {3'd0, 3'd2, 3'd1, 3'd2, 6'b110110, 1'b1, 1'b0});
    end
    start = 1'b1; miss1 = 1'b1; tick(); miss1 = 1'b0;
    checks++;
    if (b_obs !== {3'd0, 3'd2, 3'd1, 3'd2, 6'b110110, 1'b1, 1'b0}) begin
      errors++; $display("FAIL miss_in_over got %h want %h", b_obs, {3'd0, 3'd2, 3'd1, 3'd2, 6'b110110, 1'b1, 1'b0});
    end
    tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({a_still, a_serve} !== 2'b10) begin
        errors++; $display("FAIL pulse_ignored cyc %0d got %b want 10", i, {a_still, a_serve});
      end
    end
    checks++;
    if (a_s2 !== 3'd2) begin
      errors++; $display("FAIL miss_in_newball got %0d want 2", a_s2);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (a_obs !== {3'd0, 3'd2, 3'd0, 3'd0, 6'b110001, 1'b0, 1'b1}) begin
      errors++; $display("FAIL late_serve got %h want %h", a_obs, {3'd0, 3'd2, 3'd0, 3'd0, 6'b110001, 1'b0, 1'b1});
    end
  endtask

  task automatic test_exhaust();
    rst = 1'b1; tick(); rst = 1'b0;
    serve_after(1); miss(0, 1); serve_after(D); miss(0, 1); serve_after(D); miss(0, 1);
    checks++;
    if (a_obs !== {3'd3, 3'd0, 3'd0, 3'd1, 6'b110110, 1'b1, 1'b0}) begin
      errors++; $display("FAIL exhaust_over got %h want %h", a_obs, {3'd3, 3'd0, 3'd0, 3'd1, 6'b110110, 1'b1, 1'b0});
    end
    start = 1'b1;
    for (int i = 0; i < D - 1; i++) begin
      tick();
      checks++;
      if ({a_txt, a_serve} !== {6'b110110, 1'b0}) begin
        errors++; $display("FAIL over_hold cyc %0d got %h want %h", i, {a_txt, a_serve}, {6'b110110, 1'b0});
      end
    end
    start = 1'b0; tick();
    checks++;
    if (a_obs !== {3'd0, 3'd0, 3'd3, 3'd0, 6'b111011, 1'b1, 1'b0}) begin
      errors++; $display("FAIL over_to_newgame got %h want %h", a_obs, {3'd0, 3'd0, 3'd3, 3'd0, 6'b111011, 1'b1, 1'b0});
    end
  endtask

  task automatic test_tie();
    rst = 1'b1; tick(); rst = 1'b0;
    serve_after(1); miss(1, 0); serve_after(D); miss(0, 1); serve_after(D); miss(1, 1);
    checks++;
    if (a_obs !== {3'd2, 3'd2, 3'd0, 3'd0, 6'b110010, 1'b1, 1'b0}) begin
      errors++; $display("FAIL tie_a got %h want %h", a_obs, {3'd2, 3'd2, 3'd0, 3'd0, 6'b110010, 1'b1, 1'b0});
    end
    checks++;
    if (b_obs !== {3'd2, 3'd2, 3'd0, 3'd0, 6'b110010, 1'b1, 1'b0}) begin
      errors++; $display("FAIL tie_b got %h want %h", b_obs, {3'd2, 3'd2, 3'd0, 3'd0, 6'b110010, 1'b1, 1'b0});
    end
    repeat (D) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom % 150) == 0;
      start = ($urandom % 3) == 0;
      miss1 = ($urandom % 12) == 0;
      miss2 = ($urandom % 12) == 0;
      tick();
      checks++;
      if (a_obs !== mpack(ma)) begin
        errors++;
        if (errors < 20) $display("FAIL random_a cyc %0d got %h want %h", i, a_obs, mpack(ma));
      end
      checks++;
      if (b_obs !== mpack(mb)) begin
        errors++;
        if (errors < 20) $display("FAIL random_b cyc %0d got %h want %h", i, b_obs, mpack(mb));
      end
    end
    rst = 1'b0; start = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
  endtask

  initial begin
    ma = mreset();
    mb = mreset();
    test_reset();
    test_serve();
    test_holdoff();
    test_exhaust();
    test_tie();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
